// File: rtl/down_count_sequence_monitor.sv
// Health monitor for a MOD-N down counter: checks each sampled count against
// the expected decrement-with-wrap and reports lock, wrap and error status.
module down_count_sequence_monitor #(
  parameter int MOD_VALUE = 32,
  parameter int LOCK_LEN  = 4,
  parameter int WRAP_W    = 8,
  parameter int ERR_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         en,
  input  logic [$clog2(MOD_VALUE)-1:0] cnt_in,
  output logic                         locked,
  output logic                         wrap_pulse,
  output logic                         err_pulse,
  output logic                         err_sticky,
  output logic [WRAP_W-1:0]            wrap_count,
  output logic [ERR_W-1:0]             err_count
);

  // state   | meaning
  // IDLE    | waiting for the first enabled sample after reset/clear
  // ACQUIRE | looking for an in-range sample to seed prev
  // TRACK   | comparing each sample against prev-1 (with wrap)

  localparam int             CW     = $clog2(MOD_VALUE);
  localparam logic [CW:0]    MOD_V  = (CW+1)'(MOD_VALUE);
  localparam logic [CW-1:0]  MAX_V  = CW'(MOD_VALUE - 1);
  localparam logic [7:0]     LOCK_V = 8'(LOCK_LEN);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_TRACK   = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_prev;
  logic [7:0]      r_run;

  logic            w_in_range;
  logic [CW-1:0]   w_exp;
  logic            w_match;
  logic [7:0]      w_run_inc;
  logic [ERR_W-1:0] w_err_inc;

  assign w_in_range = {1'b0, cnt_in} < MOD_V;
  assign w_exp      = (r_prev == '0) ? MAX_V : r_prev - CW'(1);
  assign w_match    = w_in_range && (cnt_in == w_exp);
  assign w_run_inc  = (r_run >= LOCK_V) ? r_run : r_run + 8'd1;
  // err_count saturates instead of rolling over
  assign w_err_inc  = (&err_count) ? err_count : err_count + ERR_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_prev     <= '0;
      r_run      <= '0;
      locked     <= 1'b0;
      wrap_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      wrap_count <= '0;
      err_count  <= '0;
    end else begin
      wrap_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      if (clear) begin
        r_state    <= S_IDLE;
        r_prev     <= '0;
        r_run      <= '0;
        locked     <= 1'b0;
        err_sticky <= 1'b0;
        wrap_count <= '0;
        err_count  <= '0;
      end else if (en) begin
        case (r_state)
          S_IDLE, S_ACQUIRE: begin
            if (w_in_range) begin
              r_prev  <= cnt_in;
              r_run   <= '0;
              r_state <= S_TRACK;
            end else begin
              err_pulse  <= 1'b1;
              err_sticky <= 1'b1;
              err_count  <= w_err_inc;
              r_state    <= S_ACQUIRE;
            end
          end
          S_TRACK: begin
            if (w_match) begin
              r_prev <= cnt_in;
              r_run  <= w_run_inc;
              if (w_run_inc >= LOCK_V) locked <= 1'b1;
              if (r_prev == '0) begin
                wrap_pulse <= 1'b1;
                wrap_count <= wrap_count + WRAP_W'(1);
              end
            end else begin
              err_pulse  <= 1'b1;
              err_sticky <= 1'b1;
              err_count  <= w_err_inc;
              locked     <= 1'b0;
              r_run      <= '0;
              // resync on the faulty value when it is at least a legal count
              if (w_in_range) r_prev <= cnt_in;
              else            r_state <= S_ACQUIRE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
